// File: rtl/sccb_cfg_sequencer.sv
// Camera power-up and table-driven SCCB configuration master.
// Raises cam_en, waits for the sensor to wake, then writes every table entry as a 4-byte SCCB write.
module sccb_cfg_sequencer #(
    parameter int          CLK_DIV   = 125,
    parameter logic [19:0] PWRUP_DLY = 20'd1000000,
    parameter logic [15:0] GAP_DLY   = 16'd1000,
    parameter logic [6:0]  SLAVE_ID  = 7'h36,
    parameter int          TBL_AW    = 8
) (
    input  logic              ILA_clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic [TBL_AW:0]   wr_count,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic              cam_en,
    output logic              sccb_clk,
    output logic              sccb_clk_en,
    output logic              sccb_data_out,
    output logic              sccb_data_en,
    input  logic              sccb_data_in
);

    localparam int              QW       = $clog2(CLK_DIV);
    localparam logic [QW-1:0]   Q_LAST   = QW'(CLK_DIV - 1);
    localparam logic [19:0]     PWR_LAST = PWRUP_DLY - 20'd1;
    localparam logic [19:0]     GAP_LAST = {4'd0, GAP_DLY - 16'd1};
    localparam logic [TBL_AW:0] WR_MAX   = {1'b1, {TBL_AW{1'b0}}};

    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, FETCH, START, BYTE, ACK, STOP, GAP, DONE_ST
    } state_t;

    state_t      state;
    logic [QW-1:0] qcnt;
    logic [1:0]  quarter;
    logic [2:0]  bitn;
    logic [1:0]  byten;
    logic [7:0]  shreg;
    logic [23:0] entry;
    logic [19:0] dcnt;
    logic        skip_dly;
    logic        qtick;
    logic [7:0]  next_byte;

    function automatic logic [7:0] byte_sel(input logic [1:0] idx, input logic [23:0] e);
        case (idx)
            2'd0:    return {SLAVE_ID, 1'b0};
            2'd1:    return e[23:16];
            2'd2:    return e[15:8];
            default: return e[7:0];
        endcase
    endfunction

    assign qtick = (qcnt == Q_LAST);

    always_comb begin
        next_byte = byte_sel(byten + 2'd1, entry);
    end

    always_ff @(posedge ILA_clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            ack_err       <= 1'b0;
            wr_count      <= '0;
            tbl_addr      <= '0;
            cam_en        <= 1'b0;
            sccb_clk      <= 1'b1;
            sccb_clk_en   <= 1'b0;
            sccb_data_out <= 1'b1;
            sccb_data_en  <= 1'b1;
            qcnt          <= '0;
            quarter       <= '0;
            bitn          <= '0;
            byten         <= '0;
            shreg         <= '0;
            entry         <= '0;
            dcnt          <= '0;
            skip_dly      <= 1'b0;
        end else begin
            // Quarter-bit timebase; state branches below override quarter where a phase restarts.
            if (state inside {START, BYTE, ACK, STOP}) begin
                qcnt <= qtick ? '0 : qcnt + 1'b1;
                if (qtick) quarter <= quarter + 2'd1;
            end

            case (state)
                IDLE, DONE_ST: begin
                    if (start) begin
                        state    <= PWR_WAIT;
                        skip_dly <= cam_en;
                        cam_en   <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        ack_err  <= 1'b0;
                        wr_count <= '0;
                        tbl_addr <= '0;
                        dcnt     <= '0;
                    end
                end
                PWR_WAIT: begin
                    if (skip_dly || dcnt == PWR_LAST) state <= FETCH;
                    else                              dcnt  <= dcnt + 20'd1;
                end
                FETCH: begin
                    entry <= tbl_data;
                    if (tbl_data[23:8] == 16'hFFFF) begin
                        state <= DONE_ST;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state         <= START;
                        qcnt          <= '0;
                        quarter       <= '0;
                        bitn          <= '0;
                        byten         <= '0;
                        shreg         <= {SLAVE_ID, 1'b0};
                        sccb_clk_en   <= 1'b1;
                        sccb_clk      <= 1'b1;
                        sccb_data_en  <= 1'b0;
                        sccb_data_out <= 1'b1;
                    end
                end
                START: begin
                    if (qtick) begin
                        case (quarter)
                            2'd0: sccb_data_out <= 1'b0;
                            2'd1: sccb_clk      <= 1'b0;
                            default: begin
                                state         <= BYTE;
                                quarter       <= '0;
                                sccb_data_out <= shreg[7];
                            end
                        endcase
                    end
                end
                BYTE: begin
                    if (qtick) begin
                        if (quarter == 2'd1) sccb_clk <= 1'b1;
                        if (quarter == 2'd3) begin
                            sccb_clk <= 1'b0;
                            if (bitn == 3'd7) begin
                                state        <= ACK;
                                sccb_data_en <= 1'b1;
                            end else begin
                                bitn          <= bitn + 3'd1;
                                shreg         <= {shreg[6:0], 1'b0};
                                sccb_data_out <= shreg[6];
                            end
                        end
                    end
                end
                ACK: begin
                    if (qtick) begin
                        if (quarter == 2'd1) sccb_clk <= 1'b1;
                        if (quarter == 2'd3) begin
                            // SCCB treats the ninth bit as don't-care: a NACK is only flagged.
                            if (sccb_data_in) ack_err <= 1'b1;
                            sccb_clk     <= 1'b0;
                            sccb_data_en <= 1'b0;
                            if (byten == 2'd3) begin
                                state         <= STOP;
                                sccb_data_out <= 1'b0;
                            end else begin
                                state         <= BYTE;
                                byten         <= byten + 2'd1;
                                bitn          <= '0;
                                shreg         <= next_byte;
                                sccb_data_out <= next_byte[7];
                            end
                        end
                    end
                end
                STOP: begin
                    if (qtick) begin
                        case (quarter)
                            2'd1: sccb_clk      <= 1'b1;
                            2'd2: sccb_data_out <= 1'b1;
                            2'd3: begin
                                sccb_clk_en   <= 1'b0;
                                sccb_data_en  <= 1'b1;
                                sccb_clk      <= 1'b1;
                                sccb_data_out <= 1'b1;
                                if (wr_count != WR_MAX) wr_count <= wr_count + 1'b1;
                                tbl_addr <= tbl_addr + 1'b1;
                                if (&tbl_addr) begin
                                    state <= DONE_ST;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state <= GAP;
                                    dcnt  <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                GAP: begin
                    if (dcnt == GAP_LAST) state <= FETCH;
                    else                  dcnt  <= dcnt + 20'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: small timing parameters, pad/slave model and bus monitor.
module tb_sccb_cfg_sequencer;

    localparam int          CD  = 4;
    localparam int          AW  = 2;
    localparam logic [19:0] PWR = 20'd10;
    localparam logic [15:0] GAP = 16'd20;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, ack_err, cam_en;
    logic [AW:0]   wr_count;
    logic [AW-1:0] tbl_addr;
    logic [23:0]   tbl_data;
    logic          sccb_clk, sccb_clk_en, sccb_data_out, sccb_data_en, sccb_data_in;

    logic [23:0] table_mem [0:3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sccb_cfg_sequencer #(
        .CLK_DIV(CD), .PWRUP_DLY(PWR), .GAP_DLY(GAP), .SLAVE_ID(7'h36), .TBL_AW(AW)
    ) dut (
        .ILA_clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
        .ack_err(ack_err), .wr_count(wr_count), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .cam_en(cam_en), .sccb_clk(sccb_clk), .sccb_clk_en(sccb_clk_en),
        .sccb_data_out(sccb_data_out), .sccb_data_en(sccb_data_en), .sccb_data_in(sccb_data_in)
    );

    // Synchronous table ROM: data follows the address by one cycle.
    always @(posedge clk) tbl_data <= table_mem[tbl_addr];

    // Pads with pull-ups; the slave pulls SDA low in every ACK slot except nack_sel.
    int   nack_sel = 0;
    int   ack_idx  = 0;
    logic scl_pad, sda_pad, slave_low;
    assign slave_low    = sccb_clk_en && (ack_idx >= 1) && (ack_idx <= 4) && (ack_idx != nack_sel);
    assign sda_pad      = sccb_data_en ? ~slave_low : sccb_data_out;
    assign scl_pad      = sccb_clk_en ? sccb_clk : 1'b1;
    assign sccb_data_in = sda_pad;

    int            cyc = 0;
    int            n_tx = 0;
    int            t_start [0:31];
    int            t_end   [0:31];
    int            rise_cnt = 0;
    logic          bits [0:63];
    int            busy_rise = 0;
    int            n_addr = 0;
    logic [AW-1:0] addr_log [0:127];
    logic          p_en = 1'b0, p_scl = 1'b1, p_den = 1'b1, p_busy = 1'b0;
    logic [AW-1:0] p_addr = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sccb_clk_en === 1'b1 && p_en === 1'b0) begin
            t_start[n_tx % 32] <= cyc;
            rise_cnt <= 0;
            ack_idx  <= 0;
        end
        if (sccb_clk_en === 1'b0 && p_en === 1'b1) begin
            t_end[n_tx % 32] <= cyc;
            n_tx <= n_tx + 1;
        end
        if (sccb_clk_en === 1'b1 && p_en === 1'b1 && scl_pad === 1'b1 && p_scl === 1'b0 && rise_cnt < 64) begin
            bits[rise_cnt] <= sda_pad;
            rise_cnt <= rise_cnt + 1;
        end
        if (sccb_clk_en === 1'b1 && sccb_data_en === 1'b1 && p_den === 1'b0) ack_idx <= ack_idx + 1;
        if (busy === 1'b1 && p_busy === 1'b0) busy_rise <= cyc;
        if (tbl_addr !== p_addr && n_addr < 128) begin
            addr_log[n_addr] <= tbl_addr;
            n_addr <= n_addr + 1;
        end
        p_en   <= sccb_clk_en;
        p_scl  <= scl_pad;
        p_den  <= sccb_data_en;
        p_busy <= busy;
        p_addr <= tbl_addr;
    end

    function automatic logic [7:0] got_byte(input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7-j] = bits[9*k + j];
        return b;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] got;
        logic [9:0] exp;
        got = {busy, done, ack_err, cam_en, sccb_clk, sccb_clk_en, sccb_data_out, sccb_data_en, scl_pad, sda_pad};
        exp = 10'b0000_1011_11;
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required %b", got, exp);
        end
        n_tests++;
        if (wr_count !== 3'd0 || tbl_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_counters: wr_count=%0d tbl_addr=%0d required 0/0", wr_count, tbl_addr);
        end
    endtask

    task automatic test_single_write();
        int base;
        logic [7:0] exp_b [4];
        exp_b = '{8'h6C, 8'h30, 8'h08, 8'h82};
        table_mem[0] = 24'h300882;
        table_mem[1] = 24'hFFFF00;
        base = n_tx;
        pulse_start();
        n_tests++;
        if (cam_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cam_en: cam_en=%b busy=%b required 1/1", cam_en, busy);
        end
        wait_done(3000);
        n_tests++;
        if (n_tx - base !== 1) begin
            n_fail++;
            $display("FAIL single_tx_count: got %0d required 1", n_tx - base);
        end
        // Ten-cycle power-up wait followed by the one-cycle table fetch.
        n_tests++;
        if (t_start[base % 32] - busy_rise !== 11) begin
            n_fail++;
            $display("FAIL single_pwrup_latency: got %0d required 11", t_start[base % 32] - busy_rise);
        end
        n_tests++;
        if (t_end[base % 32] - t_start[base % 32] !== 604) begin
            n_fail++;
            $display("FAIL single_tx_len: got %0d required 604", t_end[base % 32] - t_start[base % 32]);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (got_byte(k) !== exp_b[k]) begin
                n_fail++;
                $display("FAIL single_byte%0d: got %h required %h", k, got_byte(k), exp_b[k]);
            end
        end
        n_tests++;
        if (rise_cnt !== 37 || bits[36] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_stop: rises=%0d sda_at_stop=%b required 37/0", rise_cnt, bits[36]);
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_count !== 3'd1 || ack_err !== 1'b0 || tbl_addr !== 2'd1) begin
            n_fail++;
            $display("FAIL single_status: done=%b busy=%b wr=%0d ack_err=%b addr=%0d required 1/0/1/0/1",
                     done, busy, wr_count, ack_err, tbl_addr);
        end
    endtask

    task automatic test_nack();
        int base;
        logic [7:0] exp_b [4];
        exp_b = '{8'h6C, 8'h30, 8'h08, 8'h82};
        nack_sel = 3;
        base = n_tx;
        pulse_start();
        wait_done(3000);
        nack_sel = 0;
        // cam_en already high: no power-up wait, only PWR_WAIT and FETCH cycles.
        n_tests++;
        if (t_start[base % 32] - busy_rise !== 2) begin
            n_fail++;
            $display("FAIL nack_restart_latency: got %0d required 2", t_start[base % 32] - busy_rise);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (got_byte(k) !== exp_b[k]) begin
                n_fail++;
                $display("FAIL nack_byte%0d: got %h required %h", k, got_byte(k), exp_b[k]);
            end
        end
        n_tests++;
        if (ack_err !== 1'b1 || done !== 1'b1 || wr_count !== 3'd1 || rise_cnt !== 37) begin
            n_fail++;
            $display("FAIL nack_status: ack_err=%b done=%b wr=%0d rises=%0d required 1/1/1/37",
                     ack_err, done, wr_count, rise_cnt);
        end
    endtask

    task automatic test_multi_gap();
        int base, abase;
        logic [7:0] exp_b [4];
        exp_b = '{8'h6C, 8'h30, 8'h02, 8'hCC};
        table_mem[0] = 24'h3000AA;
        table_mem[1] = 24'h3001BB;
        table_mem[2] = 24'h3002CC;
        table_mem[3] = 24'hFFFF00;
        base  = n_tx;
        abase = n_addr;
        pulse_start();
        n_tests++;
        if (ack_err !== 1'b0 || wr_count !== 3'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_clear_on_start: ack_err=%b wr=%0d done=%b required 0/0/0", ack_err, wr_count, done);
        end
        wait_done(6000);
        n_tests++;
        if (n_tx - base !== 3) begin
            n_fail++;
            $display("FAIL multi_tx_count: got %0d required 3", n_tx - base);
        end
        for (int k = 1; k < 3; k++) begin
            n_tests++;
            if (t_start[(base + k) % 32] - t_end[(base + k - 1) % 32] !== 21) begin
                n_fail++;
                $display("FAIL multi_gap%0d: got %0d required 21", k,
                         t_start[(base + k) % 32] - t_end[(base + k - 1) % 32]);
            end
        end
        n_tests++;
        if (n_addr - abase !== 4) begin
            n_fail++;
            $display("FAIL multi_addr_changes: got %0d required 4", n_addr - abase);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (addr_log[(abase + k) % 128] !== 2'(k)) begin
                n_fail++;
                $display("FAIL multi_addr_seq%0d: got %0d required %0d", k, addr_log[(abase + k) % 128], k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (got_byte(k) !== exp_b[k]) begin
                n_fail++;
                $display("FAIL multi_last_byte%0d: got %h required %h", k, got_byte(k), exp_b[k]);
            end
        end
        n_tests++;
        if (wr_count !== 3'd3 || tbl_addr !== 2'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_status: wr=%0d addr=%0d busy=%b required 3/3/0", wr_count, tbl_addr, busy);
        end
    endtask

    task automatic test_exhaust();
        int base;
        table_mem[0] = 24'h300111;
        table_mem[1] = 24'h300222;
        table_mem[2] = 24'h300333;
        table_mem[3] = 24'h300444;
        base = n_tx;
        pulse_start();
        wait_done(8000);
        n_tests++;
        if (n_tx - base !== 4) begin
            n_fail++;
            $display("FAIL exhaust_tx_count: got %0d required 4", n_tx - base);
        end
        n_tests++;
        if (wr_count !== 3'd4 || tbl_addr !== 2'd0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL exhaust_status: wr=%0d addr=%0d done=%b busy=%b required 4/0/1/0",
                     wr_count, tbl_addr, done, busy);
        end
        n_tests++;
        if (got_byte(2) !== 8'h04 || got_byte(3) !== 8'h44) begin
            n_fail++;
            $display("FAIL exhaust_last_entry: got %h%h required 0444", got_byte(2), got_byte(3));
        end
    endtask

    task automatic test_busy_ignore();
        int base;
        table_mem[0] = 24'h300882;
        table_mem[1] = 24'hFFFF00;
        base = n_tx;
        pulse_start();
        repeat (40) @(negedge clk);
        pulse_start();
        repeat (200) @(negedge clk);
        pulse_start();
        wait_done(3000);
        n_tests++;
        if (n_tx - base !== 1 || t_end[base % 32] - t_start[base % 32] !== 604) begin
            n_fail++;
            $display("FAIL busy_ignore_tx: count=%0d len=%0d required 1/604",
                     n_tx - base, t_end[base % 32] - t_start[base % 32]);
        end
        n_tests++;
        if (wr_count !== 3'd1 || got_byte(3) !== 8'h82 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_ignore_status: wr=%0d data=%h done=%b required 1/82/1", wr_count, got_byte(3), done);
        end
    endtask

    task automatic test_mid_reset();
        int base, k;
        pulse_start();
        k = 0;
        while (!(sccb_clk_en === 1'b1 && rise_cnt >= 12 && rise_cnt < 18) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k >= 2000) begin
            n_fail++;
            $display("FAIL mid_reset_reach_byte2: rises=%0d required 12..17", rise_cnt);
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if (sccb_clk_en !== 1'b0 || sccb_data_en !== 1'b1 || cam_en !== 1'b0 || busy !== 1'b0 || scl_pad !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_release: clk_en=%b data_en=%b cam_en=%b busy=%b scl=%b required 0/1/0/0/1",
                     sccb_clk_en, sccb_data_en, cam_en, busy, scl_pad);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        base = n_tx;
        pulse_start();
        n_tests++;
        if (cam_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_cam_en: got %b required 1", cam_en);
        end
        wait_done(3000);
        n_tests++;
        if (n_tx - base !== 1 || t_start[base % 32] - busy_rise !== 11) begin
            n_fail++;
            $display("FAIL mid_reset_rerun: count=%0d latency=%0d required 1/11",
                     n_tx - base, t_start[base % 32] - busy_rise);
        end
        n_tests++;
        if (t_end[base % 32] - t_start[base % 32] !== 604 || wr_count !== 3'd1 || got_byte(0) !== 8'h6C) begin
            n_fail++;
            $display("FAIL mid_reset_tx: len=%0d wr=%0d id=%h required 604/1/6c",
                     t_end[base % 32] - t_start[base % 32], wr_count, got_byte(0));
        end
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        test_single_write();
        test_nack();
        test_multi_gap();
        test_exhaust();
        test_busy_ignore();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 50000 cycles, required completion");
        $fatal(1, "watchdog");
    end

endmodule
